// File: rtl/cr_pkg.sv
// Shared BCD time-field definitions for the chronometer path.
package cr_pkg;

  typedef logic [7:0] bcd_t;

  localparam bcd_t SEG_MAX = 8'h59;
  localparam bcd_t MIN_MAX = 8'h59;
  localparam bcd_t HR_MAX  = 8'h23;
  localparam bcd_t DAY_MAX = 8'h31;
  localparam bcd_t DAY_MIN = 8'h01;

  // Both nibbles must be decimal digits.
  function automatic logic bcd_valid(input bcd_t v);
    return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9);
  endfunction

endpackage

// File: rtl/cr_bcd_field_step.sv
// Combinational BCD +/-1 with wrap between min_val and max_val.
module bcd_step
  import cr_pkg::*;
(
  input  bcd_t value,
  input  logic dir,
  input  bcd_t min_val,
  input  bcd_t max_val,
  output bcd_t next_val,
  output logic wrap
);

  // For valid BCD operands a binary compare equals the decimal compare.
  always_comb begin
    next_val = min_val;
    wrap     = 1'b0;
    if (!bcd_valid(value) || (value < min_val) || (value > max_val)) begin
      next_val = min_val;
      wrap     = 1'b0;
    end else if (dir == 1'b0) begin
      wrap = (value == max_val);
      if (value == max_val) begin
        next_val = min_val;
      end else if (value[3:0] == 4'h9) begin
        next_val = {value[7:4] + 4'h1, 4'h0};
      end else begin
        next_val = {value[7:4], value[3:0] + 4'h1};
      end
    end else begin
      wrap = (value == min_val);
      if (value == min_val) begin
        next_val = max_val;
      end else if (value[3:0] == 4'h0) begin
        next_val = {value[7:4] - 4'h1, 4'h9};
      end else begin
        next_val = {value[7:4], value[3:0] - 4'h1};
      end
    end
  end

endmodule

// File: rtl/cr_bcd_field.sv
// Two-digit BCD time field: load, edit, tick counting and a zero-latency
// carry so fields can be rippled into a full chronometer chain.
module cr_bcd_field
  import cr_pkg::*;
#(
  parameter bcd_t MAX_VAL = 8'h59,
  parameter bcd_t MIN_VAL = 8'h00,
  parameter bcd_t RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  input  logic       tick,
  input  logic       dir,
  input  logic       hold,
  output logic [7:0] dato,
  output logic       carry,
  output logic       at_min,
  output logic       load_err
);

  logic edit_s;
  logic step_dir_s;
  bcd_t step_val_s;
  logic step_wrap_s;
  logic load_ok_s;
  bcd_t next_s;
  logic err_s;

  assign edit_s     = inc | dec;
  // Edits and ticks share one stepper; an edit picks its own direction.
  assign step_dir_s = edit_s ? dec : dir;
  assign load_ok_s  = bcd_valid(din) && (din >= MIN_VAL) && (din <= MAX_VAL);

  bcd_step u_step (
    .value    (dato),
    .dir      (step_dir_s),
    .min_val  (MIN_VAL),
    .max_val  (MAX_VAL),
    .next_val (step_val_s),
    .wrap     (step_wrap_s)
  );

  assign carry = tick & ~hold & ~reset & ~load & ~inc & ~dec & step_wrap_s;

  // Next-value selection: load > edit > tick.
  always_comb begin
    next_s = dato;
    err_s  = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        next_s = din;
      end else begin
        err_s = 1'b1;
      end
    end else if (edit_s) begin
      if (inc && dec) begin
        next_s = dato;
      end else begin
        next_s = step_val_s;
      end
    end else if (tick && !hold) begin
      next_s = step_val_s;
    end else begin
      next_s = dato;
    end
  end

  // Field state and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato     <= RST_VAL;
      load_err <= 1'b0;
      at_min   <= (RST_VAL == MIN_VAL);
    end else begin
      dato     <= next_s;
      load_err <= err_s;
      at_min   <= (next_s == MIN_VAL);
    end
  end

endmodule

// File: tb/tb_cr_bcd_field.sv
// Directed self-checking bench for cr_bcd_field (seconds, day and cascaded minutes).
module tb_cr_bcd_field;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] a_din, b_din, m_din;
  logic a_load, a_inc, a_dec, a_tick, a_dir, a_hold;
  logic b_load, b_inc, b_dec, b_tick, b_dir, b_hold;
  logic m_load, m_inc, m_dec, m_dir, m_hold;
  logic [7:0] a_dato, b_dato, m_dato;
  logic a_carry, a_at_min, a_load_err;
  logic b_carry, b_at_min, b_load_err;
  logic m_carry, m_at_min, m_load_err;

  int n_cmp = 0;
  int n_err = 0;

  cr_bcd_field #(.MAX_VAL(8'h59), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_sec (
    .clk(clk), .reset(reset), .din(a_din), .load(a_load), .inc(a_inc), .dec(a_dec),
    .tick(a_tick), .dir(a_dir), .hold(a_hold), .dato(a_dato), .carry(a_carry),
    .at_min(a_at_min), .load_err(a_load_err));

  cr_bcd_field #(.MAX_VAL(8'h31), .MIN_VAL(8'h01), .RST_VAL(8'h01)) u_day (
    .clk(clk), .reset(reset), .din(b_din), .load(b_load), .inc(b_inc), .dec(b_dec),
    .tick(b_tick), .dir(b_dir), .hold(b_hold), .dato(b_dato), .carry(b_carry),
    .at_min(b_at_min), .load_err(b_load_err));

  cr_bcd_field #(.MAX_VAL(8'h59), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_min (
    .clk(clk), .reset(reset), .din(m_din), .load(m_load), .inc(m_inc), .dec(m_dec),
    .tick(a_carry), .dir(m_dir), .hold(m_hold), .dato(m_dato), .carry(m_carry),
    .at_min(m_at_min), .load_err(m_load_err));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_load = 1'b0; a_inc = 1'b0; a_dec = 1'b0; a_tick = 1'b0; a_dir = 1'b0; a_hold = 1'b0;
    b_load = 1'b0; b_inc = 1'b0; b_dec = 1'b0; b_tick = 1'b0; b_dir = 1'b0; b_hold = 1'b0;
    m_load = 1'b0; m_inc = 1'b0; m_dec = 1'b0; m_dir = 1'b0; m_hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_tick = 1'b1; a_load = 1'b1; a_din = 8'h30;
    b_load = 1'b1; b_din = 8'h20;
    #1;
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b exp 0", a_carry); end
    cyc(); cyc();
    n_cmp++; if (a_dato !== 8'h00) begin n_err++; $display("FAIL reset_dato got %h exp 00", a_dato); end
    n_cmp++; if (a_at_min !== 1'b1) begin n_err++; $display("FAIL reset_at_min got %b exp 1", a_at_min); end
    n_cmp++; if (a_load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err got %b exp 0", a_load_err); end
    n_cmp++; if (b_dato !== 8'h01) begin n_err++; $display("FAIL reset_day_dato got %h exp 01", b_dato); end
    n_cmp++; if (b_at_min !== 1'b1) begin n_err++; $display("FAIL reset_day_at_min got %b exp 1", b_at_min); end
    reset = 1'b0;
    idle_all();
  endtask

  task automatic test_up_wrap();
    a_load = 1'b1; a_din = 8'h58;
    cyc();
    a_load = 1'b0;
    n_cmp++; if (a_dato !== 8'h58) begin n_err++; $display("FAIL up_load got %h exp 58", a_dato); end
    a_tick = 1'b1; a_dir = 1'b0;
    #1;
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL up_carry_first got %b exp 0", a_carry); end
    cyc();
    n_cmp++; if (a_dato !== 8'h59) begin n_err++; $display("FAIL up_step59 got %h exp 59", a_dato); end
    n_cmp++; if (a_carry !== 1'b1) begin n_err++; $display("FAIL up_carry_wrap got %b exp 1", a_carry); end
    cyc();
    a_tick = 1'b0;
    #1;
    n_cmp++; if (a_dato !== 8'h00) begin n_err++; $display("FAIL up_wrap got %h exp 00", a_dato); end
    n_cmp++; if (a_at_min !== 1'b1) begin n_err++; $display("FAIL up_wrap_at_min got %b exp 1", a_at_min); end
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL up_carry_idle got %b exp 0", a_carry); end
    a_load = 1'b1; a_din = 8'h09;
    cyc();
    a_load = 1'b0; a_tick = 1'b1;
    cyc();
    a_tick = 1'b0;
    n_cmp++; if (a_dato !== 8'h10) begin n_err++; $display("FAIL up_bcd_09_10 got %h exp 10", a_dato); end
    n_cmp++; if (a_at_min !== 1'b0) begin n_err++; $display("FAIL up_at_min_clear got %b exp 0", a_at_min); end
  endtask

  task automatic test_down_wrap();
    b_load = 1'b1; b_din = 8'h01;
    cyc();
    b_load = 1'b0; b_tick = 1'b1; b_dir = 1'b1;
    #1;
    n_cmp++; if (b_carry !== 1'b1) begin n_err++; $display("FAIL down_carry got %b exp 1", b_carry); end
    cyc();
    b_tick = 1'b0;
    n_cmp++; if (b_dato !== 8'h31) begin n_err++; $display("FAIL down_wrap got %h exp 31", b_dato); end
    n_cmp++; if (b_at_min !== 1'b0) begin n_err++; $display("FAIL down_at_min got %b exp 0", b_at_min); end
    b_load = 1'b1; b_din = 8'h10;
    cyc();
    b_load = 1'b0; b_tick = 1'b1;
    #1;
    n_cmp++; if (b_carry !== 1'b0) begin n_err++; $display("FAIL down_carry_mid got %b exp 0", b_carry); end
    cyc();
    b_tick = 1'b0; b_dir = 1'b0;
    n_cmp++; if (b_dato !== 8'h09) begin n_err++; $display("FAIL down_bcd_10_09 got %h exp 09", b_dato); end
  endtask

  task automatic test_load_validation();
    a_load = 1'b1; a_din = 8'h5A;
    cyc();
    a_load = 1'b0;
    n_cmp++; if (a_load_err !== 1'b1) begin n_err++; $display("FAIL load_5A_err got %b exp 1", a_load_err); end
    n_cmp++; if (a_dato !== 8'h10) begin n_err++; $display("FAIL load_5A_dato got %h exp 10", a_dato); end
    cyc();
    n_cmp++; if (a_load_err !== 1'b0) begin n_err++; $display("FAIL load_err_pulse got %b exp 0", a_load_err); end
    a_load = 1'b1; a_din = 8'h60;
    cyc();
    n_cmp++; if (a_load_err !== 1'b1) begin n_err++; $display("FAIL load_60_err got %b exp 1", a_load_err); end
    n_cmp++; if (a_dato !== 8'h10) begin n_err++; $display("FAIL load_60_dato got %h exp 10", a_dato); end
    a_din = 8'h42;
    cyc();
    a_load = 1'b0;
    n_cmp++; if (a_dato !== 8'h42) begin n_err++; $display("FAIL load_42 got %h exp 42", a_dato); end
    n_cmp++; if (a_load_err !== 1'b0) begin n_err++; $display("FAIL load_42_err got %b exp 0", a_load_err); end
    b_load = 1'b1; b_din = 8'h00;
    cyc();
    b_load = 1'b0;
    n_cmp++; if (b_load_err !== 1'b1) begin n_err++; $display("FAIL load_below_min_err got %b exp 1", b_load_err); end
    n_cmp++; if (b_dato !== 8'h09) begin n_err++; $display("FAIL load_below_min_dato got %h exp 09", b_dato); end
  endtask

  task automatic test_priority();
    a_load = 1'b1; a_inc = 1'b1; a_tick = 1'b1; a_din = 8'h10;
    cyc();
    n_cmp++; if (a_dato !== 8'h10) begin n_err++; $display("FAIL prio_load_wins got %h exp 10", a_dato); end
    a_inc = 1'b0; a_tick = 1'b0; a_din = 8'h59;
    cyc();
    a_din = 8'h30; a_tick = 1'b1;
    #1;
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL prio_load_masks_carry got %b exp 0", a_carry); end
    cyc();
    a_load = 1'b0; a_tick = 1'b0;
    n_cmp++; if (a_dato !== 8'h30) begin n_err++; $display("FAIL prio_load30 got %h exp 30", a_dato); end
    a_inc = 1'b1; a_dec = 1'b1;
    cyc();
    n_cmp++; if (a_dato !== 8'h30) begin n_err++; $display("FAIL prio_inc_dec got %h exp 30", a_dato); end
    a_dec = 1'b0;
    cyc(); cyc();
    n_cmp++; if (a_dato !== 8'h32) begin n_err++; $display("FAIL edit_inc_level got %h exp 32", a_dato); end
    a_inc = 1'b0; a_load = 1'b1; a_din = 8'h59;
    cyc();
    a_load = 1'b0; a_inc = 1'b1; a_tick = 1'b1;
    #1;
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL edit_no_carry got %b exp 0", a_carry); end
    cyc();
    a_inc = 1'b0; a_tick = 1'b0;
    n_cmp++; if (a_dato !== 8'h00) begin n_err++; $display("FAIL edit_inc_wrap got %h exp 00", a_dato); end
    a_dec = 1'b1;
    cyc();
    a_dec = 1'b0;
    n_cmp++; if (a_dato !== 8'h59) begin n_err++; $display("FAIL edit_dec_wrap got %h exp 59", a_dato); end
    a_hold = 1'b1; a_tick = 1'b1;
    #1;
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL hold_carry got %b exp 0", a_carry); end
    cyc();
    a_hold = 1'b0; a_tick = 1'b0;
    n_cmp++; if (a_dato !== 8'h59) begin n_err++; $display("FAIL hold_dato got %h exp 59", a_dato); end
  endtask

  task automatic test_cascade();
    a_load = 1'b1; a_din = 8'h59; m_load = 1'b1; m_din = 8'h59;
    cyc();
    a_load = 1'b0; m_load = 1'b0; a_tick = 1'b1; a_dir = 1'b0;
    cyc();
    a_tick = 1'b0;
    n_cmp++; if (a_dato !== 8'h00) begin n_err++; $display("FAIL cascade_sec got %h exp 00", a_dato); end
    n_cmp++; if (m_dato !== 8'h00) begin n_err++; $display("FAIL cascade_min got %h exp 00", m_dato); end
    cyc();
    n_cmp++; if (m_dato !== 8'h00) begin n_err++; $display("FAIL cascade_min_stable got %h exp 00", m_dato); end
  endtask

  initial begin
    a_din = 8'h00; b_din = 8'h00; m_din = 8'h00;
    idle_all();
    reset = 1'b1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_validation();
    test_priority();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cr_bcd_field.md
Name: cr_bcd_field

Overview:
Parametrised successor to the plain enabled seconds register of the chronometer path. It holds one two-digit BCD time field (seconds, minutes, hours, day, …) and supports:
- parallel load from the data bus;
- user editing (increment/decrement with wrap);
- tick-driven counting up or down;
- a combinational carry/borrow output, so fields cascade into a full chronometer/timer chain feeding the display and the RTC write path.

Parameters:
MAX_VAL, 8'h59, largest legal value, BCD encoded (e.g. 8'h23 for hours, 8'h31 for days).
MIN_VAL, 8'h00, smallest legal value, BCD encoded (8'h01 for day/month fields).
RST_VAL, 8'h00, value loaded on reset; must satisfy MIN_VAL ≤ RST_VAL ≤ MAX_VAL.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
din  in  8  BCD value for parallel load
load  in  1  load din this cycle
inc  in  1  edit: step value up by one with wrap
dec  in  1  edit: step value down by one with wrap
tick  in  1  count pulse (1-cycle strobe from the timebase or the previous field's carry)
dir  in  1  count direction for tick: 0 = up, 1 = down
hold  in  1  freeze tick counting; load/inc/dec still act
dato  out  8  current field value, registered BCD
carry  out  1  combinational; wrap event on this cycle's tick
at_min  out  1  registered; dato == MIN_VAL
load_err  out  1  registered 1-cycle pulse; rejected load

Behaviour:
- Reset is synchronous, active-high, and has the highest priority:
  - dato ← RST_VAL; load_err ← 0; at_min ← (RST_VAL == MIN_VAL).
  - A tick or load in the same cycle as reset is ignored.
- Update priority per cycle: reset > load > edit (inc/dec) > tick. Only the highest-priority active request acts.
- Load:
  - Accepted when both nibbles of din are ≤ 9 and MIN_VAL ≤ din ≤ MAX_VAL (BCD compare). Then dato ← din on the next edge.
  - Otherwise dato is unchanged and load_err = 1 for exactly one cycle.
  - load_err is 0 in every cycle without a rejected load.
- Edit:
  - inc alone: dato ← dato+1, MAX_VAL wraps to MIN_VAL.
  - dec alone: dato ← dato−1, MIN_VAL wraps to MAX_VAL.
  - inc and dec together: no change.
  - Edits never assert carry.
- Tick (only when hold = 0 and no higher-priority request):
  - dir = 0: dato steps up, wrapping MAX_VAL → MIN_VAL.
  - dir = 1: dato steps down, wrapping MIN_VAL → MAX_VAL.
- carry:
  - Asserted = tick & ~hold & ~reset & ~load & ~inc & ~dec & (dir ? dato==MIN_VAL : dato==MAX_VAL).
  - It asserts in the same cycle as the wrapping tick (zero latency), so it can drive the next field's tick directly.
- BCD step:
  - Low nibble 9 → 0 with carry into the high nibble (up).
  - Low nibble 0 → 9 with borrow (down).
  - The result never contains a nibble > 9.
- Latency: load, edit and tick take effect one clock after the request; at_min follows dato in the same edge (computed from the next value).
- Timing: tick, inc and dec are level-sampled each cycle; holding any of them high for N cycles produces N steps. Debounce and one-shot shaping are done upstream.
- Cascade contract: carry depends only on the field's own inputs and state, so a ripple chain of k fields has no combinational loop.
- Illegal state: if dato is ever outside [MIN_VAL, MAX_VAL], the next tick or edit loads MIN_VAL. This is recovery only; it is not reachable from legal stimulus.

Decomposition:
- Shared package cr_pkg:
  - BCD field constants: SEG_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23, DAY_MAX=8'h31, DAY_MIN=8'h01.
  - 8-bit BCD type and a bcd_valid function.
- One combinational sub-module, bcd_step:
  - Inputs: value, dir, MIN/MAX.
  - Outputs: next value with wrap, plus a wrap flag.
  - Instantiated once and shared by the edit and tick paths (the mux selects the direction).

Test Plan:
- Reset: reset=1 with RST_VAL=8'h00, tick=1, load=1, din=8'h30 → next cycle dato=8'h00, at_min=1, load_err=0.
- Up-count wrap: MAX_VAL=8'h59, dato=8'h58, dir=0, tick for 2 cycles → dato 8'h59 then 8'h00; carry=1 only during the second tick; a BCD step 8'h09→8'h10 is also checked.
- Down-count wrap: MIN_VAL=8'h01, MAX_VAL=8'h31, dato=8'h01, dir=1, tick → dato=8'h31, carry=1 that cycle; dato 8'h10 down → 8'h09.
- Load validation: din=8'h5A → rejected, load_err pulse of 1 cycle, dato unchanged; din=8'h60 with MAX 8'h59 → rejected; din=8'h42 → dato=8'h42 next cycle.
- Priority: load=1, inc=1, tick=1 together with din=8'h10 → dato=8'h10, carry=0; inc=dec=1 → no change; hold=1 with tick → no change, carry=0.
- Cascade: two instances (seconds→minutes) with the seconds carry driving the minutes tick, starting 8'h59:8'h59, dir=0, one tick → 8'h00:8'h00 in a single cycle.
